// File: rtl/cpu_core.sv
// cpu_core: multi-cycle accumulator CPU with a ready-strobed memory port.
// Ports: clk, rst (async active-low), run; mem_* bus; pc/ac/z/halted status.
module cpu_core #(
  parameter int DW   = 8,
  parameter int AW   = 16,
  parameter int NREG = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          run,
  output logic [AW-1:0] mem_addr,
  output logic          mem_rd,
  output logic          mem_wr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [AW-1:0] pc_out,
  output logic [DW-1:0] ac_out,
  output logic          z_out,
  output logic          halted
);

  localparam int RW = (NREG > 1) ? $clog2(NREG) : 1;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LDAC = 4'h1;
  localparam logic [3:0] OP_STAC = 4'h2;
  localparam logic [3:0] OP_MVAC = 4'h3;
  localparam logic [3:0] OP_MOVR = 4'h4;
  localparam logic [3:0] OP_JUMP = 4'h5;
  localparam logic [3:0] OP_JMPZ = 4'h6;
  localparam logic [3:0] OP_JPNZ = 4'h7;
  localparam logic [3:0] OP_ADD  = 4'h8;
  localparam logic [3:0] OP_SUB  = 4'h9;
  localparam logic [3:0] OP_INAC = 4'hA;
  localparam logic [3:0] OP_CLAC = 4'hB;
  localparam logic [3:0] OP_AND  = 4'hC;
  localparam logic [3:0] OP_OR   = 4'hD;
  localparam logic [3:0] OP_XOR  = 4'hE;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_ADDRLO,
    S_ADDRHI,
    S_EXEC,
    S_MEMRD,
    S_MEMWR,
    S_HALT
  } state_t;

  state_t          r_state;
  logic [AW-1:0]   r_pc;
  logic [AW-1:0]   r_tr;
  logic [DW-1:0]   r_ac;
  logic [DW-1:0]   r_ir;
  logic            r_z;
  logic            r_fpend;
  logic [DW-1:0]   r_regs [NREG];

  logic [3:0]      w_op;
  logic [RW-1:0]   w_ri;
  logic [DW-1:0]   w_rv;
  logic [DW-1:0]   w_alu;
  logic            w_alu_op;
  logic            w_jmp;
  logic            w_need_addr;
  logic            w_fetch_req;
  logic            w_unused_ir;

  assign w_op        = r_ir[DW-1:DW-4];
  assign w_ri        = r_ir[RW-1:0];
  assign w_rv        = r_regs[w_ri];
  assign w_unused_ir = ^r_ir;

  assign w_need_addr = w_op inside {OP_LDAC, OP_STAC, OP_JUMP,
                                    OP_JMPZ, OP_JPNZ};

  assign w_jmp = (w_op == OP_JUMP) ||
                 ((w_op == OP_JMPZ) && r_z) ||
                 ((w_op == OP_JPNZ) && !r_z);

  // Once a fetch has been requested it stays up until acknowledged,
  // even if run falls while the memory is still busy.
  assign w_fetch_req = (r_state == S_FETCH) && (run || r_fpend);

  always_comb begin
    w_alu    = r_ac;
    w_alu_op = 1'b1;
    case (w_op)
      OP_ADD:  w_alu = r_ac + w_rv;
      OP_SUB:  w_alu = r_ac - w_rv;
      OP_INAC: w_alu = r_ac + DW'(1);
      OP_CLAC: w_alu = '0;
      OP_AND:  w_alu = r_ac & w_rv;
      OP_OR:   w_alu = r_ac | w_rv;
      OP_XOR:  w_alu = r_ac ^ w_rv;
      default: w_alu_op = 1'b0;
    endcase
  end

  // Reset gates the strobes directly so they fall at once,
  // regardless of the clock.
  assign mem_rd = rst && (w_fetch_req ||
                          (r_state == S_ADDRLO) ||
                          (r_state == S_ADDRHI) ||
                          (r_state == S_MEMRD));
  assign mem_wr = rst && (r_state == S_MEMWR);

  assign mem_addr  = ((r_state == S_MEMRD) ||
                      (r_state == S_MEMWR)) ? r_tr : r_pc;
  assign mem_wdata = r_ac;
  assign pc_out    = r_pc;
  assign ac_out    = r_ac;
  assign z_out     = r_z;
  assign halted    = (r_state == S_HALT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_FETCH;
      r_pc    <= '0;
      r_tr    <= '0;
      r_ac    <= '0;
      r_ir    <= '0;
      r_z     <= 1'b0;
      r_fpend <= 1'b0;
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      unique case (r_state)
        S_FETCH: begin
          if (w_fetch_req) begin
            if (mem_ready) begin
              r_ir    <= mem_rdata;
              r_pc    <= r_pc + AW'(1);
              r_fpend <= 1'b0;
              r_state <= S_DECODE;
            end else begin
              r_fpend <= 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (w_need_addr) begin
            r_state <= S_ADDRLO;
          end else if (w_op == OP_HALT) begin
            r_state <= S_HALT;
          end else begin
            r_state <= S_EXEC;
          end
        end
        S_ADDRLO: begin
          if (mem_ready) begin
            r_tr[DW-1:0] <= mem_rdata;
            r_pc         <= r_pc + AW'(1);
            r_state      <= S_ADDRHI;
          end
        end
        S_ADDRHI: begin
          if (mem_ready) begin
            r_tr[AW-1:DW] <= mem_rdata;
            r_pc          <= r_pc + AW'(1);
            r_state       <= S_EXEC;
          end
        end
        S_EXEC: begin
          if (w_alu_op) begin
            r_ac <= w_alu;
            r_z  <= (w_alu == '0);
          end
          if (w_op == OP_MVAC) begin
            r_regs[w_ri] <= r_ac;
          end
          if (w_op == OP_MOVR) begin
            r_ac <= w_rv;
          end
          if (w_jmp) begin
            r_pc <= r_tr;
          end
          if (w_op == OP_LDAC) begin
            r_state <= S_MEMRD;
          end else if (w_op == OP_STAC) begin
            r_state <= S_MEMWR;
          end else begin
            r_state <= S_FETCH;
          end
        end
        S_MEMRD: begin
          if (mem_ready) begin
            r_ac    <= mem_rdata;
            r_state <= S_FETCH;
          end
        end
        S_MEMWR: begin
          if (mem_ready) begin
            r_state <= S_FETCH;
          end
        end
        S_HALT: begin
          r_state <= S_HALT;
        end
        default: begin
          r_state <= S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_core.sv
// tb_cpu_core: directed program runs against a byte memory model
// with configurable wait states and a write scoreboard.
module tb_cpu_core;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic [15:0] mem_addr;
  logic        mem_rd;
  logic        mem_wr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;
  logic        mem_ready;
  logic [15:0] pc_out;
  logic [7:0]  ac_out;
  logic        z_out;
  logic        halted;

  cpu_core dut (
    .clk       (clk),
    .rst       (rst),
    .run       (run),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .mem_ready (mem_ready),
    .pc_out    (pc_out),
    .ac_out    (ac_out),
    .z_out     (z_out),
    .halted    (halted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  typedef struct packed {
    logic [15:0] a;
    logic [7:0]  d;
  } wr_t;

  logic [7:0]  mem [0:65535];
  wr_t         wq [$];
  int          wait_n = 0;
  int          cnt    = 0;
  bit          spur   = 0;
  logic        p_pend = 0;
  logic [25:0] p_req;

  // Memory responder: decides ready at the falling edge so the
  // core sees it at the next rising edge.
  always @(negedge clk) begin
    if (!rst) begin
      cnt = 0;
      p_pend = 0;
      mem_ready = 0;
    end else if (mem_rd || mem_wr) begin
      chk("rd_wr_excl", {31'd0, mem_rd & mem_wr}, 32'd0);
      if (p_pend)
        chk("req_hold", {6'd0, mem_addr, mem_wdata, mem_rd, mem_wr},
            {6'd0, p_req});
      if (cnt >= wait_n) begin
        mem_ready = 1;
        cnt = 0;
        p_pend = 0;
        if (mem_rd) begin
          mem_rdata = mem[mem_addr];
        end else begin
          wr_t e;
          mem[mem_addr] = mem_wdata;
          chk("wr_expected", {31'd0, wq.size() != 0}, 32'd1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", {16'd0, mem_addr}, {16'd0, e.a});
            chk("wr_data", {24'd0, mem_wdata}, {24'd0, e.d});
          end
        end
      end else begin
        mem_ready = 0;
        cnt++;
        p_pend = 1;
        p_req = {mem_addr, mem_wdata, mem_rd, mem_wr};
      end
    end else begin
      mem_ready = spur;
      cnt = 0;
      p_pend = 0;
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  endtask

  task automatic ldn(input logic [15:0] base, input logic [7:0] b[$]);
    for (int i = 0; i < b.size(); i++) mem[base + 16'(i)] = b[i];
  endtask

  task automatic do_reset();
    run = 0;
    rst = 0;
    spur = 0;
    wq.delete();
    cyc();
    cyc();
    rst = 1;
  endtask

  task automatic wait_pc(input logic [15:0] a, input string tag);
    for (int i = 0; i < 2000; i++) begin
      cyc();
      if (pc_out == a) break;
    end
    chk(tag, {16'd0, pc_out}, {16'd0, a});
  endtask

  task automatic wait_halt(input string tag);
    for (int i = 0; i < 2000; i++) begin
      if (halted) break;
      cyc();
    end
    chk(tag, {31'd0, halted}, 32'd1);
  endtask

  initial begin
    logic [7:0] p[$];
    rst = 0;
    run = 0;
    mem_ready = 0;
    mem_rdata = 0;
    clear_mem();
    cyc();
    cyc();
    chk("rst_pc", {16'd0, pc_out}, 32'd0);
    chk("rst_ac", {24'd0, ac_out}, 32'd0);
    chk("rst_ctl", {28'd0, z_out, halted, mem_rd, mem_wr}, 32'd0);
    rst = 1;

    // CLAC; INAC; MVAC R0; ADD R0; HALT at zero wait
    p = {8'hB0, 8'hA0, 8'h30, 8'h80, 8'hF0};
    ldn(16'h0000, p);
    wait_n = 0;
    cyc();
    run = 1;
    for (int k = 1; k <= 14; k++) begin
      cyc();
      if (k == 3)  chk("a_clac", {23'd0, z_out, ac_out}, {23'd0, 1'b1, 8'h00});
      if (k == 6)  chk("a_inac", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h01});
      if (k == 12) chk("a_add", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h02});
      if (k == 13) chk("a_not_halted", {31'd0, halted}, 32'd0);
      if (k == 14) chk("a_halted", {15'd0, halted, pc_out}, {15'd0, 1'b1, 16'h0005});
    end
    for (int k = 0; k < 5; k++) begin
      cyc();
      chk("a_halt_hold", {29'd0, halted, mem_rd, mem_wr}, {29'd0, 3'b100});
    end

    // LDAC 0x1234 with two wait cycles on every access
    do_reset();
    clear_mem();
    p = {8'h10, 8'h34, 8'h12, 8'hF0};
    ldn(16'h0000, p);
    mem[16'h1234] = 8'h7F;
    wait_n = 2;
    run = 1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      if (k == 13) chk("l_before", {24'd0, ac_out}, 32'h00);
      if (k == 14) chk("l_ac", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h7F});
      if (k == 17) chk("l_not_halted", {31'd0, halted}, 32'd0);
      if (k == 18) chk("l_halted", {15'd0, halted, pc_out}, {15'd0, 1'b1, 16'h0004});
    end

    // Mixed program, three wait cycles per access
    do_reset();
    clear_mem();
    p = {8'hB0, 8'hA0, 8'h31, 8'hB0, 8'h91, 8'hA0, 8'h60, 8'h40, 8'h00};
    ldn(16'h0000, p);
    p = {8'h70, 8'h80, 8'h00, 8'h10, 8'h34, 8'h12, 8'h10, 8'h35, 8'h12,
         8'h20, 8'hCD, 8'hAB, 8'h32, 8'hB0, 8'hA0, 8'hE2, 8'hC2, 8'hD1,
         8'h42, 8'h81, 8'h50, 8'h00, 8'h01};
    ldn(16'h0040, p);
    p = {8'h20, 8'h00, 8'h02, 8'hF0};
    ldn(16'h0100, p);
    mem[16'h1234] = 8'h7F;
    mem[16'h1235] = 8'h5A;
    wq.push_back('{a: 16'hABCD, d: 8'h5A});
    wq.push_back('{a: 16'h0200, d: 8'h5B});
    wait_n = 3;
    run = 1;
    wait_pc(16'h0006, "b_pc6");
    chk("b_sub", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'hFF});
    wait_pc(16'h0007, "b_pc7");
    chk("b_inac_wrap", {23'd0, z_out, ac_out}, {23'd0, 1'b1, 8'h00});
    wait_pc(16'h0041, "b_jmpz_taken");
    wait_pc(16'h0044, "b_jpnz_not_taken");
    wait_pc(16'h0047, "b_pc47");
    chk("b_ldac", {23'd0, z_out, ac_out}, {23'd0, 1'b1, 8'h7F});
    wait_pc(16'h004A, "b_pc4a");
    chk("b_ldac2", {24'd0, ac_out}, 32'h5A);
    wait_pc(16'h0050, "b_pc50");
    chk("b_inac", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h01});
    wait_pc(16'h0051, "b_pc51");
    chk("b_xor", {24'd0, ac_out}, 32'h5B);
    wait_pc(16'h0052, "b_pc52");
    chk("b_and", {24'd0, ac_out}, 32'h5A);
    wait_pc(16'h0053, "b_pc53");
    chk("b_or", {24'd0, ac_out}, 32'h5B);
    wait_pc(16'h0054, "b_pc54");
    chk("b_movr", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h5A});
    wait_pc(16'h0055, "b_pc55");
    chk("b_add", {23'd0, z_out, ac_out}, {23'd0, 1'b0, 8'h5B});
    wait_pc(16'h0101, "b_jump");
    wait_halt("b_halt");
    chk("b_end_pc", {16'd0, pc_out}, 32'h0104);
    chk("b_wq_empty", wq.size(), 32'd0);
    chk("b_mem200", {24'd0, mem[16'h0200]}, 32'h5B);

    // PC wrap, then run=0 freezes fetch
    do_reset();
    clear_mem();
    p = {8'h50, 8'hFF, 8'hFF};
    ldn(16'h0000, p);
    mem[16'hFFFF] = 8'h00;
    wait_n = 0;
    run = 1;
    wait_pc(16'hFFFF, "c_pc_ffff");
    cyc();
    chk("c_wrap", {16'd0, pc_out}, 32'h0000);
    run = 0;
    spur = 1;
    cyc();
    cyc();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("c_frozen", {15'd0, mem_rd, pc_out}, {15'd0, 1'b0, 16'h0000});
    end
    spur = 0;

    // Reset during a MEMRD wait
    do_reset();
    clear_mem();
    p = {8'h10, 8'h34, 8'h12};
    ldn(16'h0000, p);
    mem[16'h1234] = 8'h99;
    wait_n = 0;
    run = 1;
    wait_pc(16'h0003, "d_pc3");
    wait_n = 50;
    for (int i = 0; i < 20; i++) begin
      if (mem_rd && mem_addr == 16'h1234) break;
      cyc();
    end
    chk("d_memrd", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h1234});
    cyc();
    rst = 0;
    #1;
    chk("d_drop", {7'd0, mem_rd, ac_out, pc_out}, 32'd0);
    wait_n = 0;
    cyc();
    rst = 1;
    #1;
    chk("d_first_fetch", {15'd0, mem_rd, mem_addr}, {15'd0, 1'b1, 16'h0000});
    cyc();
    chk("d_pc1", {8'd0, ac_out, pc_out}, {8'd0, 8'h00, 16'h0001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
